// File: rtl/dmem_mmio_responder_pkg.sv
// Shared definitions for the data-memory / MMIO responder:
// default base addresses, MMIO register offsets, STATUS bit positions
// and a small helper for sticky write-1-to-clear flags.
package dmem_mmio_responder_pkg;

    // Default byte base addresses of the RAM and the 32-byte MMIO window
    localparam logic [31:0] DEF_RAM_BASE  = 32'h1001_0000;
    localparam logic [31:0] DEF_MMIO_BASE = 32'hFFFF_0000;

    // Byte offsets of the MMIO registers inside the window
    localparam logic [4:0] OFF_CYCLE  = 5'h00;
    localparam logic [4:0] OFF_TCMP   = 5'h04;
    localparam logic [4:0] OFF_STATUS = 5'h08;
    localparam logic [4:0] OFF_TXD    = 5'h0C;
    localparam logic [4:0] OFF_LED    = 5'h10;

    // STATUS register bit positions
    localparam int ST_TIMER_HIT    = 0;
    localparam int ST_FIFO_FULL    = 1;
    localparam int ST_FIFO_EMPTY   = 2;
    localparam int ST_TX_OVF       = 3;
    localparam int ST_BUS_ERR_SEEN = 4;
    localparam int ST_COUNT_LSB    = 8;

    // Sticky flag next state: a set in the same cycle as a clear wins
    function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
        return set | (cur & ~clr);
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// CPU data-memory bus: the CPU (master) drives address, store data and
// store strobe; the responder (slave) returns combinational load data.
interface dmem_mmio_responder_if;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_wena;
    logic [31:0] dm_rdata;

    modport master (
        output dm_addr,
        output dm_wdata,
        output dm_wena,
        input  dm_rdata
    );

    modport slave (
        input  dm_addr,
        input  dm_wdata,
        input  dm_wena,
        output dm_rdata
    );
endinterface

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Byte FIFO feeding the debug TX sink. Power-of-2 depth, pointers wrap
// naturally, count runs 0..DEPTH. A push into a full FIFO is still taken
// when a pop happens in the same cycle. Reset (active-low, async) flushes
// pointers, count and storage so the head byte reads 0 after reset.
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     push_ok
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       buf_q [DEPTH];
    logic [7:0]       buf_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = buf_q[rd_ptr_q];
    assign count   = count_q;
    assign push_ok = do_push;

    // Next-state for storage, pointers and occupancy count
    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            buf_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO state registers, flushed by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Responder end of the CPU data-memory bus: word-addressed data RAM plus
// a 32-byte MMIO window (CYCLE, TCMP, STATUS, TXD, LED). Loads are
// combinational, stores commit on the rising clock edge. Reset is
// asynchronous and active-low on the port named 'reset'.
// Optional feature macro DMEM_BUS_ERR_EN adds the bus_err output and the
// sticky STATUS.bus_err_seen flag; without it unmapped accesses are
// silently absorbed.
module dmem_mmio_responder
    import dmem_mmio_responder_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
    parameter int          TX_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_mmio_responder_if.slave bus,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [15:0]          led,
    output logic                 timer_irq
`ifdef DMEM_BUS_ERR_EN
    ,
    output logic                 bus_err
`endif
);
    localparam int          RAM_AW      = $clog2(RAM_WORDS);
    localparam int          CNT_W       = $clog2(TX_DEPTH) + 1;
    localparam logic [29:0] RAM_BASE_W  = RAM_BASE[31:2];
    localparam logic [29:0] RAM_WORDS_W = 30'(RAM_WORDS);

    logic [29:0]       word_addr, ram_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_hit, mmio_hit, ram_we;
    logic [4:0]        reg_off;
    logic              reg_known, access_err;
    logic              wr_tcmp, wr_status, wr_txd, wr_led;

    logic [31:0]       mem_q [RAM_WORDS];
    logic [31:0]       cycle_q, cycle_d;
    logic [31:0]       tcmp_q, tcmp_d;
    logic              timer_hit_q, timer_hit_d;
    logic              tx_ovf_q, tx_ovf_d;
    logic [15:0]       led_q, led_d;
    logic              timer_set;

    logic [7:0]        fifo_head;
    logic              fifo_full, fifo_empty, fifo_push_ok;
    logic [CNT_W-1:0]  fifo_count;

    logic [31:0]       status_word, rd_word;
    logic              unused_bits;

    // Address decode on the word index; the RAM test is a single
    // subtract-and-compare so addresses below the base wrap high and miss
    assign word_addr   = bus.dm_addr[31:2];
    assign ram_off     = word_addr - RAM_BASE_W;
    assign ram_hit     = (ram_off < RAM_WORDS_W);
    assign ram_idx     = ram_off[RAM_AW-1:0];
    assign mmio_hit    = (bus.dm_addr[31:5] == MMIO_BASE[31:5]);
    assign reg_off     = {bus.dm_addr[4:2], 2'b00};
    assign ram_we      = bus.dm_wena & ram_hit;
    assign access_err  = ~ram_hit & ~(mmio_hit & reg_known);

    // MMIO register select and per-register store strobes
    always_comb begin
        reg_known = 1'b0;
        wr_tcmp   = 1'b0;
        wr_status = 1'b0;
        wr_txd    = 1'b0;
        wr_led    = 1'b0;
        if (mmio_hit) begin
            case (reg_off)
                OFF_CYCLE:  reg_known = 1'b1;
                OFF_TCMP:   begin reg_known = 1'b1; wr_tcmp   = bus.dm_wena; end
                OFF_STATUS: begin reg_known = 1'b1; wr_status = bus.dm_wena; end
                OFF_TXD:    begin reg_known = 1'b1; wr_txd    = bus.dm_wena; end
                OFF_LED:    begin reg_known = 1'b1; wr_led    = bus.dm_wena; end
                default:    reg_known = 1'b0;
            endcase
        end
    end

    // Data RAM: single write port, contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= bus.dm_wdata;
        end
    end

    tx_fifo #(
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txd),
        .push_data (bus.dm_wdata[7:0]),
        .pop       (tx_valid & tx_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .push_ok   (fifo_push_ok)
    );

    assign tx_valid  = ~fifo_empty;
    assign tx_data   = fifo_head;
    assign led       = led_q;
    assign timer_irq = timer_hit_q;

    // Next-state for counter, compare timer, sticky flags and LED; the
    // compare uses the old TCMP so a TCMP store only matters next cycle
    always_comb begin
        cycle_d     = cycle_q + 32'd1;
        tcmp_d      = wr_tcmp ? bus.dm_wdata : tcmp_q;
        timer_set   = (tcmp_q != '0) && (cycle_d == tcmp_q);
        timer_hit_d = sticky_next(timer_hit_q, timer_set, wr_status & bus.dm_wdata[ST_TIMER_HIT]);
        tx_ovf_d    = sticky_next(tx_ovf_q, wr_txd & ~fifo_push_ok, wr_status & bus.dm_wdata[ST_TX_OVF]);
        led_d       = wr_led ? bus.dm_wdata[15:0] : led_q;
    end

`ifdef DMEM_BUS_ERR_EN
    logic bus_err_seen_q, bus_err_seen_d;

    assign bus_err        = access_err;
    assign bus_err_seen_d = sticky_next(bus_err_seen_q, access_err,
                                        wr_status & bus.dm_wdata[ST_BUS_ERR_SEEN]);

    // Sticky record of any unmapped or reserved access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_err_seen_q <= 1'b0;
        end else begin
            bus_err_seen_q <= bus_err_seen_d;
        end
    end
`endif

    // Register state, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q     <= '0;
            tcmp_q      <= '0;
            timer_hit_q <= 1'b0;
            tx_ovf_q    <= 1'b0;
            led_q       <= '0;
        end else begin
            cycle_q     <= cycle_d;
            tcmp_q      <= tcmp_d;
            timer_hit_q <= timer_hit_d;
            tx_ovf_q    <= tx_ovf_d;
            led_q       <= led_d;
        end
    end

    // STATUS register assembly
    always_comb begin
        status_word                              = '0;
        status_word[ST_TIMER_HIT]                = timer_hit_q;
        status_word[ST_FIFO_FULL]                = fifo_full;
        status_word[ST_FIFO_EMPTY]               = fifo_empty;
        status_word[ST_TX_OVF]                   = tx_ovf_q;
`ifdef DMEM_BUS_ERR_EN
        status_word[ST_BUS_ERR_SEEN]             = bus_err_seen_q;
`endif
        status_word[ST_COUNT_LSB +: CNT_W]       = fifo_count;
    end

    // Combinational load mux; unmapped, reserved and TXD read as zero
    always_comb begin
        rd_word = '0;
        if (ram_hit) begin
            rd_word = mem_q[ram_idx];
        end else if (mmio_hit) begin
            case (reg_off)
                OFF_CYCLE:  rd_word = cycle_q;
                OFF_TCMP:   rd_word = tcmp_q;
                OFF_STATUS: rd_word = status_word;
                OFF_LED:    rd_word = {16'h0000, led_q};
                default:    rd_word = '0;
            endcase
        end
    end

    assign bus.dm_rdata = rd_word;

`ifdef DMEM_BUS_ERR_EN
    assign unused_bits = ^{bus.dm_addr[1:0], ram_off[29:RAM_AW]};
`else
    assign unused_bits = ^{bus.dm_addr[1:0], ram_off[29:RAM_AW], access_err};
`endif

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed testbench for dmem_mmio_responder: RAM, timer, TX FIFO,
// mid-transfer reset and unmapped accesses, with hand-computed results.
module tb_dmem_mmio_responder;

    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] A_TCMP   = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
    localparam logic [31:0] A_TXD    = 32'hFFFF_000C;
    localparam logic [31:0] A_LED    = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [15:0] led;
    logic        timer_irq;
`ifdef DMEM_BUS_ERR_EN
    logic        bus_err;
`endif

    int          passed = 0;
    int          total = 0;
    int          cyc;
    logic [31:0] rv;

    dmem_mmio_responder_if bus_if ();

    dmem_mmio_responder dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .led       (led),
        .timer_irq (timer_irq)
`ifdef DMEM_BUS_ERR_EN
        ,
        .bus_err   (bus_err)
`endif
    );

    // 100 MHz clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_if.dm_addr  = a;
        bus_if.dm_wdata = d;
        bus_if.dm_wena  = 1'b1;
        tick();
        bus_if.dm_wena  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus_if.dm_addr = a;
        bus_if.dm_wena = 1'b0;
        #1;
        d = bus_if.dm_rdata;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        total++; if (tx_valid !== 1'b0) $display("[TB] FAIL rst_tx_valid: got %b want 0", tx_valid); else passed++;
        total++; if (tx_data !== 8'h00) $display("[TB] FAIL rst_tx_data: got %h want 00", tx_data); else passed++;
        total++; if (led !== 16'h0000) $display("[TB] FAIL rst_led: got %h want 0000", led); else passed++;
        total++; if (timer_irq !== 1'b0) $display("[TB] FAIL rst_irq: got %b want 0", timer_irq); else passed++;
        tick();
        reset = 1'b1;
        rd(A_CYCLE, rv);
        total++; if (rv !== 32'd0) $display("[TB] FAIL rst_cycle0: got %h want 0", rv); else passed++;
        rd(A_STATUS, rv);
        total++; if ((rv & 32'h0000_0F0F) !== 32'h0000_0004) $display("[TB] FAIL rst_status: got %h want 00000004", rv & 32'h0F0F); else passed++;
        tick();
        rd(A_CYCLE, rv);
        total++; if (rv !== 32'd1) $display("[TB] FAIL rst_cycle1: got %h want 1", rv); else passed++;
    endtask

    task automatic test_ram();
        wr(32'h1001_0000, 32'h1111_2222);
        wr(32'h1001_0004, 32'h0123_4567);
        bus_if.dm_addr  = 32'h1001_0004;
        bus_if.dm_wdata = 32'hDEAD_BEEF;
        bus_if.dm_wena  = 1'b1;
        #1;
        total++; if (bus_if.dm_rdata !== 32'h0123_4567) $display("[TB] FAIL ram_old_on_write: got %h want 01234567", bus_if.dm_rdata); else passed++;
        tick();
        bus_if.dm_wena = 1'b0;
        rd(32'h1001_0004, rv);
        total++; if (rv !== 32'hDEAD_BEEF) $display("[TB] FAIL ram_rd4: got %h want deadbeef", rv); else passed++;
        rd(32'h1001_0007, rv);
        total++; if (rv !== 32'hDEAD_BEEF) $display("[TB] FAIL ram_rd7: got %h want deadbeef", rv); else passed++;
        rd(32'h1001_0000, rv);
        total++; if (rv !== 32'h1111_2222) $display("[TB] FAIL ram_rd0: got %h want 11112222", rv); else passed++;
        wr(32'h1001_0FFC, 32'hCAFE_F00D);
        wr(32'h1001_1000, 32'h5555_5555);
        rd(32'h1001_0FFC, rv);
        total++; if (rv !== 32'hCAFE_F00D) $display("[TB] FAIL ram_last_word: got %h want cafef00d", rv); else passed++;
        rd(32'h1001_1000, rv);
        total++; if (rv !== 32'h0) $display("[TB] FAIL ram_past_end: got %h want 0", rv); else passed++;
        rd(32'h1001_0000, rv);
        total++; if (rv !== 32'h1111_2222) $display("[TB] FAIL ram_no_alias: got %h want 11112222", rv); else passed++;
        tick();
        rd(32'h1000_FFFC, rv);
        total++; if (rv !== 32'h0) $display("[TB] FAIL ram_below_base: got %h want 0", rv); else passed++;
    endtask

    task automatic test_timer();
        tick();
        do_reset();
        bus_if.dm_addr  = A_TCMP;
        bus_if.dm_wdata = 32'd20;
        bus_if.dm_wena  = 1'b1;
        tick();
        bus_if.dm_wena  = 1'b0;
        cyc = 1;
        while (cyc < 20) begin
            tick();
            cyc++;
            if (cyc == 19) begin
                rd(A_CYCLE, rv);
                total++; if (rv !== 32'd19) $display("[TB] FAIL tmr_cycle19: got %0d want 19", rv); else passed++;
                total++; if (timer_irq !== 1'b0) $display("[TB] FAIL tmr_irq_early: got %b want 0", timer_irq); else passed++;
            end
        end
        rd(A_CYCLE, rv);
        total++; if (rv !== 32'd20) $display("[TB] FAIL tmr_cycle20: got %0d want 20", rv); else passed++;
        total++; if (timer_irq !== 1'b1) $display("[TB] FAIL tmr_irq_hit: got %b want 1", timer_irq); else passed++;
        rd(A_STATUS, rv);
        total++; if (rv[0] !== 1'b1) $display("[TB] FAIL tmr_status_hit: got %b want 1", rv[0]); else passed++;
        wr(A_TCMP, 32'd30);
        cyc = 21;
        rd(A_TCMP, rv);
        total++; if (rv !== 32'd30) $display("[TB] FAIL tmr_tcmp_rd: got %0d want 30", rv); else passed++;
        wr(A_STATUS, 32'd1);
        cyc = 22;
        total++; if (timer_irq !== 1'b0) $display("[TB] FAIL tmr_w1c: got %b want 0", timer_irq); else passed++;
        while (cyc < 29) begin
            tick();
            cyc++;
        end
        total++; if (timer_irq !== 1'b0) $display("[TB] FAIL tmr_before_rehit: got %b want 0", timer_irq); else passed++;
        wr(A_STATUS, 32'd1);
        cyc = 30;
        total++; if (timer_irq !== 1'b1) $display("[TB] FAIL tmr_set_wins: got %b want 1", timer_irq); else passed++;
        wr(A_STATUS, 32'd1);
        cyc = 31;
        total++; if (timer_irq !== 1'b0) $display("[TB] FAIL tmr_clear_later: got %b want 0", timer_irq); else passed++;
        rd(A_STATUS, rv);
        total++; if (rv[0] !== 1'b0) $display("[TB] FAIL tmr_status_clr: got %b want 0", rv[0]); else passed++;
    endtask

    task automatic test_fifo_stall();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(A_TXD, 32'h0000_0041 + 32'(i));
        end
        rd(A_STATUS, rv);
        total++; if ((rv & 32'h0F0E) !== 32'h0802) $display("[TB] FAIL stall_full_status: got %h want 00000802", rv & 32'h0F0E); else passed++;
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) $display("[TB] FAIL stall_head: got %b/%h want 1/41", tx_valid, tx_data); else passed++;
        wr(A_TXD, 32'h0000_0049);
        rd(A_STATUS, rv);
        total++; if ((rv & 32'h0F0E) !== 32'h080A) $display("[TB] FAIL stall_ovf: got %h want 0000080a", rv & 32'h0F0E); else passed++;
        total++; if (tx_data !== 8'h41) $display("[TB] FAIL stall_hold: got %h want 41", tx_data); else passed++;
        rd(A_TXD, rv);
        total++; if (rv !== 32'h0) $display("[TB] FAIL txd_read: got %h want 0", rv); else passed++;
        wr(A_STATUS, 32'h0000_0008);
        rd(A_STATUS, rv);
        total++; if (rv[3] !== 1'b0) $display("[TB] FAIL ovf_w1c: got %b want 0", rv[3]); else passed++;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (tx_valid !== 1'b1 || tx_data !== 8'h41 + 8'(i)) $display("[TB] FAIL drain_%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, 8'h41 + 8'(i)); else passed++;
            tick();
        end
        total++; if (tx_valid !== 1'b0) $display("[TB] FAIL drain_empty: got %b want 0", tx_valid); else passed++;
        tx_ready = 1'b0;
    endtask

    task automatic test_full_concurrent();
        logic [7:0] exp_bytes [8];
        exp_bytes = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h5A};
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(A_TXD, 32'h0000_0050 + 32'(i));
        end
        tx_ready = 1'b1;
        wr(A_TXD, 32'h0000_005A);
        tx_ready = 1'b0;
        rd(A_STATUS, rv);
        total++; if ((rv & 32'h0F0E) !== 32'h0802) $display("[TB] FAIL conc_status: got %h want 00000802", rv & 32'h0F0E); else passed++;
        total++; if (tx_data !== 8'h51) $display("[TB] FAIL conc_head: got %h want 51", tx_data); else passed++;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (tx_valid !== 1'b1 || tx_data !== exp_bytes[i]) $display("[TB] FAIL conc_drain_%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, exp_bytes[i]); else passed++;
            tick();
        end
        total++; if (tx_valid !== 1'b0) $display("[TB] FAIL conc_empty: got %b want 0", tx_valid); else passed++;
        tx_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        wr(A_LED, 32'hFFFF_A5A5);
        rd(A_LED, rv);
        total++; if (rv !== 32'h0000_A5A5) $display("[TB] FAIL led_rd: got %h want 0000a5a5", rv); else passed++;
        total++; if (led !== 16'hA5A5) $display("[TB] FAIL led_port: got %h want a5a5", led); else passed++;
        wr(A_TXD, 32'h61);
        wr(A_TXD, 32'h62);
        wr(A_TXD, 32'h63);
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h61) $display("[TB] FAIL mr_queued: got %b/%h want 1/61", tx_valid, tx_data); else passed++;
        reset = 1'b0;
        #1;
        total++; if (tx_valid !== 1'b0) $display("[TB] FAIL mr_tx_valid: got %b want 0", tx_valid); else passed++;
        total++; if (led !== 16'h0000) $display("[TB] FAIL mr_led: got %h want 0000", led); else passed++;
        total++; if (tx_data !== 8'h00) $display("[TB] FAIL mr_tx_data: got %h want 00", tx_data); else passed++;
        reset = 1'b1;
        rd(A_CYCLE, rv);
        total++; if (rv !== 32'd0) $display("[TB] FAIL mr_cycle: got %h want 0", rv); else passed++;
        rd(A_STATUS, rv);
        total++; if ((rv & 32'h0F0F) !== 32'h0004) $display("[TB] FAIL mr_status: got %h want 00000004", rv & 32'h0F0F); else passed++;
        wr(A_TXD, 32'h77);
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) $display("[TB] FAIL mr_first_push: got %b/%h want 1/77", tx_valid, tx_data); else passed++;
        rd(A_CYCLE, rv);
        total++; if (rv !== 32'd1) $display("[TB] FAIL mr_cycle1: got %h want 1", rv); else passed++;
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic test_unmapped();
        rd(32'h0000_0100, rv);
        total++; if (rv !== 32'h0) $display("[TB] FAIL unm_low: got %h want 0", rv); else passed++;
`ifdef DMEM_BUS_ERR_EN
        total++; if (bus_err !== 1'b1) $display("[TB] FAIL unm_low_err: got %b want 1", bus_err); else passed++;
`endif
        rd(32'hFFFF_0014, rv);
        total++; if (rv !== 32'h0) $display("[TB] FAIL unm_rsvd: got %h want 0", rv); else passed++;
`ifdef DMEM_BUS_ERR_EN
        total++; if (bus_err !== 1'b1) $display("[TB] FAIL unm_rsvd_err: got %b want 1", bus_err); else passed++;
`endif
        tick();
        wr(32'hFFFF_0014, 32'h0000_FFFF);
        rd(A_LED, rv);
        total++; if (rv !== 32'h0) $display("[TB] FAIL unm_no_led_alias: got %h want 0", rv); else passed++;
        rd(32'hFFFF_001C, rv);
        total++; if (rv !== 32'h0) $display("[TB] FAIL unm_rsvd_1c: got %h want 0", rv); else passed++;
`ifdef DMEM_BUS_ERR_EN
        rd(32'h1001_0000, rv);
        total++; if (bus_err !== 1'b0) $display("[TB] FAIL mapped_no_err: got %b want 0", bus_err); else passed++;
        wr(A_STATUS, 32'h0000_0010);
        rd(A_STATUS, rv);
        total++; if (rv[4] !== 1'b0) $display("[TB] FAIL err_seen_w1c: got %b want 0", rv[4]); else passed++;
        wr(32'hFFFF_0018, 32'h0);
        rd(A_STATUS, rv);
        total++; if (rv[4] !== 1'b1) $display("[TB] FAIL err_seen_set: got %b want 1", rv[4]); else passed++;
`else
        rd(A_STATUS, rv);
        total++; if (rv[4] !== 1'b0) $display("[TB] FAIL status_bit4: got %b want 0", rv[4]); else passed++;
`endif
    endtask

    initial begin
        bus_if.dm_addr  = 32'h0;
        bus_if.dm_wdata = 32'h0;
        bus_if.dm_wena  = 1'b0;
        $display("[TB] starting dmem_mmio_responder tests");
        test_reset();
        test_ram();
        test_timer();
        test_fifo_stall();
        test_full_concurrent();
        test_mid_reset();
        test_unmapped();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
